subframe_sequencer: RTL and testbench
=====================================

// Module: subframe_sequencer
// PURPOSE
// Frame-level controller for one SubframeDecoder. Runs the decoder once per channel. Between channels it resets the decoder and rebases its RAM read port.
// Shares the single RAM read port between itself and the decoder. Tags each output sample with channel and index. Flags sample-count mismatches.
// PARAMETERS
// ADDR_W      16      RAM word-address width
// MAX_CH      8       max channels per frame; channel field width = $clog2(MAX_CH)
// WD_LIMIT    65535   watchdog cycle limit per subframe (used only with SUBFRAME_SEQ_WATCHDOG_EN)
// PORTS
// iClock          in   1       clock
// iReset          in   1       synchronous, active-high reset
// iStart          in   1       start frame; sampled in S_IDLE only
// iBlockSize      in   16      samples per subframe; latched on start
// iChannels       in   4       channel count 1..MAX_CH; latched on start (0 is treated as 1)
// iBaseAddr       in   ADDR_W  RAM word holding the first subframe header (header in high byte)
// oReadAddr       out  ADDR_W  RAM read address; RAM read latency is 1 cycle
// oDecReset       out  1       reset to the decoder
// oDecEnable      out  1       enable to the decoder
// oDecBlockSize   out  16      latched block size, driven to the decoder
// iDecReadAddr    in   ADDR_W  decoder read address, relative to the current subframe base
// iDecSampleValid in   1       decoder sample strobe
// iDecSample      in   16      decoder sample, signed
// iDecFrameDone   in   1       decoder subframe-complete flag
// oSampleValid    out  1       registered copy of iDecSampleValid while in S_RUN
// oSample         out  16      registered sample
// oChannel        out  3       channel of oSample
// oSampleIdx      out  16      index of oSample within its subframe, 0-based
// oBusy           out  1       high in every state except S_IDLE
// oFrameDone      out  1       one-cycle pulse when all channels are finished
// oError          out  1       sticky error flag; cleared by iReset or by the next iStart
// BEHAVIOUR
// - Reset values: all outputs 0 except oDecReset=1. State S_IDLE, channel counter 0, base register 0.
// - States:
//   - S_IDLE: on iStart, latch size, channel count and base; clear oError; go to S_PREFETCH.
//   - S_PREFETCH (1 cycle): oReadAddr=base, oDecReset=1. This prefetches the header word.
//   - S_LOAD (1 cycle): oReadAddr=base, oDecReset=1. The decoder captures the header from iData.
//   - S_RUN: oDecReset=0, oDecEnable=1, oReadAddr=base+iDecReadAddr (mod 2^ADDR_W).
//     - Each iDecSampleValid produces oSampleValid on the next cycle, then the index counter increments.
//     - On iDecFrameDone: base <= base+iDecReadAddr+1. If count!=block size, set oError. Go to S_NEXT.
//   - S_NEXT (1 cycle): oDecEnable=0, zero the index. If channel==channels-1, go to S_DONE; else increment channel and go to S_PREFETCH.
//   - S_DONE (1 cycle): oFrameDone=1, then S_IDLE.
// - iDecFrameDone and iDecSampleValid in the same cycle: the sample is forwarded and counted before the count check.
// - oDecEnable is 0 in every state other than S_RUN.
// - iStart outside S_IDLE is ignored.
// - iReset at any point aborts the frame within 1 cycle. No oFrameDone is emitted.
// - Index counter saturates at 0xFFFF. A count above block size sets oError.
// - The base address wraps silently at 2^ADDR_W.
// CONFIGURATION
// - SUBFRAME_SEQ_WATCHDOG_EN defined: a cycle counter runs in S_RUN and clears on entry.
//   - When it reaches WD_LIMIT: set oError, pulse oDecReset for 1 cycle, go to S_DONE (oFrameDone still pulses).
// - Macro undefined: no counter is built. S_RUN waits indefinitely for iDecFrameDone.
// STRUCTURE
// - Package subframe_seq_pkg holds:
//   - state encoding S_IDLE..S_DONE (3 bits)
//   - ADDR_W_DEF, CH_W constants
//   - function ch_last(count) returning max(count,1)-1
// - One sub-module, subframe_seq_watchdog (counter plus compare), instantiated only under the macro.
//   All other logic lives in a single always block plus output muxing.
// TESTING
// 1. Mono frame: base=0x0010, size=16, channels=1, decoder model emits 16 samples with relative addr 5 at done
//    -> oChannel=0 and oSampleIdx 0..15, then oFrameDone pulse; oError=0.
// 2. Stereo frame: base=0x0000, ch0 done at rel addr 7
//    -> ch1 S_PREFETCH drives oReadAddr=0x0008; oChannel=1 for all ch1 samples; exactly 1 oFrameDone.
// 3. Short subframe: size=16, model emits 15 samples then done
//    -> oError=1 after S_RUN; remains 1 through S_DONE and S_IDLE until the next iStart.
// 4. Reset mid-run: iReset asserted during sample 6 of ch0
//    -> next cycle S_IDLE, oDecReset=1, oBusy=0, no oFrameDone; new iStart runs a clean frame.
// 5. Coincident strobe: iDecSampleValid and iDecFrameDone together on the 16th sample
//    -> sample forwarded with idx 15; oError=0.
// 6. Watchdog (macro on, WD_LIMIT=100): model never asserts done
//    -> on cycle 100 of S_RUN: oError=1, 1-cycle oDecReset, oFrameDone pulse.

Source files
------------

// File: rtl/subframe_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the subframe sequencer.
// Optional watchdog build macro: SUBFRAME_SEQ_WATCHDOG_EN.
package subframe_seq_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int MAX_CH_DEF = 8;
    localparam int CH_W       = $clog2(MAX_CH_DEF);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Index of the last channel; a count of 0 behaves like a mono frame.
    function automatic logic [3:0] ch_last(input logic [3:0] count);
        return (count == 4'd0) ? 4'd0 : count - 4'd1;
    endfunction

endpackage

// File: rtl/subframe_seq_if.sv
// Decoder-side bundle: control from the sequencer, read address and sample stream back.
interface subframe_seq_if #(
    parameter int ADDR_W = 16
);
    logic              dec_reset;
    logic              dec_enable;
    logic [15:0]       dec_block_size;
    logic [ADDR_W-1:0] dec_read_addr;
    logic              dec_sample_valid;
    logic [15:0]       dec_sample;
    logic              dec_frame_done;

    modport master (
        output dec_reset, dec_enable, dec_block_size,
        input  dec_read_addr, dec_sample_valid, dec_sample, dec_frame_done
    );

    modport slave (
        input  dec_reset, dec_enable, dec_block_size,
        output dec_read_addr, dec_sample_valid, dec_sample, dec_frame_done
    );
endinterface

// File: rtl/subframe_seq_watchdog.sv
// Cycle counter for one S_RUN visit; trip fires on the LIMIT-th consecutive run cycle.
module subframe_seq_watchdog #(
    parameter int LIMIT = 65535
) (
    input  logic iClock,
    input  logic iReset,
    input  logic run,
    output logic trip
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_reg;

    // Dropping out of S_RUN clears the counter, so every entry starts from zero.
    always_ff @(posedge iClock) begin
        if (iReset || !run) begin
            cnt_reg <= '0;
        end else if (!trip) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign trip = run && (cnt_reg == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/subframe_sequencer.sv
// Frame controller: runs one subframe decoder per channel and shares its RAM read port.
// Build with SUBFRAME_SEQ_WATCHDOG_EN to bound the time spent waiting in S_RUN.
module subframe_sequencer
    import subframe_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_CH   = MAX_CH_DEF,
    parameter int WD_LIMIT = 65535
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [15:0]       iBlockSize,
    input  logic [3:0]        iChannels,
    input  logic [ADDR_W-1:0] iBaseAddr,
    output logic [ADDR_W-1:0] oReadAddr,
    subframe_seq_if.master    dec,
    output logic              oSampleValid,
    output logic [15:0]       oSample,
    output logic [CH_W-1:0]   oChannel,
    output logic [15:0]       oSampleIdx,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic              oError
);
    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [15:0]       block_size_reg;
    logic [CH_W-1:0]   ch_last_reg;
    logic [CH_W-1:0]   channel_reg;
    logic [15:0]       idx_reg;
    logic              error_reg;
    logic              sample_valid_reg;
    logic [15:0]       sample_reg;
    logic [CH_W-1:0]   out_channel_reg;
    logic [15:0]       out_idx_reg;

    logic [3:0]        ch_last_req;
    logic [CH_W-1:0]   ch_last_next;
    logic [15:0]       idx_next;
    logic [15:0]       count_now;
    logic              wd_trip;

    assign ch_last_req  = ch_last(iChannels);
    assign ch_last_next = (ch_last_req > 4'(MAX_CH - 1)) ? CH_W'(MAX_CH - 1)
                                                          : ch_last_req[CH_W-1:0];
    assign idx_next     = (idx_reg == 16'hFFFF) ? idx_reg : idx_reg + 16'd1;
    // A sample arriving with the done strobe is counted before the size check.
    assign count_now    = dec.dec_sample_valid ? idx_next : idx_reg;

`ifdef SUBFRAME_SEQ_WATCHDOG_EN
    subframe_seq_watchdog #(
        .LIMIT (WD_LIMIT)
    ) u_watchdog (
        .iClock (iClock),
        .iReset (iReset),
        .run    (state_reg == S_RUN),
        .trip   (wd_trip)
    );
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_reg        <= S_IDLE;
            base_reg         <= '0;
            block_size_reg   <= '0;
            ch_last_reg      <= '0;
            channel_reg      <= '0;
            idx_reg          <= '0;
            error_reg        <= 1'b0;
            sample_valid_reg <= 1'b0;
            sample_reg       <= '0;
            out_channel_reg  <= '0;
            out_idx_reg      <= '0;
        end else begin
            sample_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (iStart) begin
                        block_size_reg <= iBlockSize;
                        ch_last_reg    <= ch_last_next;
                        base_reg       <= iBaseAddr;
                        channel_reg    <= '0;
                        idx_reg        <= '0;
                        error_reg      <= 1'b0;
                        state_reg      <= S_PREFETCH;
                    end
                end
                S_PREFETCH: state_reg <= S_LOAD;
                S_LOAD:     state_reg <= S_RUN;
                S_RUN: begin
                    if (dec.dec_sample_valid) begin
                        sample_valid_reg <= 1'b1;
                        sample_reg       <= dec.dec_sample;
                        out_channel_reg  <= channel_reg;
                        out_idx_reg      <= idx_reg;
                        idx_reg          <= idx_next;
                        if (idx_reg >= block_size_reg) begin
                            error_reg <= 1'b1;
                        end
                    end
                    if (dec.dec_frame_done) begin
                        base_reg  <= base_reg + dec.dec_read_addr + ADDR_W'(1);
                        if (count_now != block_size_reg) begin
                            error_reg <= 1'b1;
                        end
                        state_reg <= S_NEXT;
                    end else if (wd_trip) begin
                        error_reg <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_NEXT: begin
                    idx_reg <= '0;
                    if (channel_reg == ch_last_reg) begin
                        state_reg <= S_DONE;
                    end else begin
                        channel_reg <= channel_reg + CH_W'(1);
                        state_reg   <= S_PREFETCH;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Outside S_RUN the port parks on the subframe base so the header word is ready.
    assign oReadAddr          = (state_reg == S_RUN) ? base_reg + dec.dec_read_addr : base_reg;
    assign dec.dec_reset      = (state_reg != S_RUN) || wd_trip;
    assign dec.dec_enable     = (state_reg == S_RUN);
    assign dec.dec_block_size = block_size_reg;

    assign oSampleValid = sample_valid_reg;
    assign oSample      = sample_reg;
    assign oChannel     = out_channel_reg;
    assign oSampleIdx   = out_idx_reg;
    assign oBusy        = (state_reg != S_IDLE);
    assign oFrameDone   = (state_reg == S_DONE);
    assign oError       = error_reg;
endmodule

// File: tb/tb_subframe_sequencer.sv
// Directed bench for subframe_sequencer with a scripted decoder model driving the bus.
module tb_subframe_sequencer;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] block_size;
    logic [3:0]  channels;
    logic [15:0] base_addr;
    logic [15:0] read_addr;
    logic        sample_valid;
    logic [15:0] sample;
    logic [2:0]  channel;
    logic [15:0] sample_idx;
    logic        busy;
    logic        frame_done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    subframe_seq_if #(.ADDR_W(16)) dec_bus ();

    subframe_sequencer #(
        .ADDR_W   (16),
        .MAX_CH   (8),
        .WD_LIMIT (100)
    ) dut (
        .iClock       (clk),
        .iReset       (rst),
        .iStart       (start),
        .iBlockSize   (block_size),
        .iChannels    (channels),
        .iBaseAddr    (base_addr),
        .oReadAddr    (read_addr),
        .dec          (dec_bus),
        .oSampleValid (sample_valid),
        .oSample      (sample),
        .oChannel     (channel),
        .oSampleIdx   (sample_idx),
        .oBusy        (busy),
        .oFrameDone   (frame_done),
        .oError       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] size, input logic [3:0] chans, input logic [15:0] base);
        block_size = size;
        channels   = chans;
        base_addr  = base;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check_value("start_busy", 32'(busy), 32'd1);
        check_value("start_err_clr", 32'(error), 32'd0);
        check_value("start_blk", 32'(dec_bus.dec_block_size), 32'(size));
    endtask

    // Entered in S_PREFETCH; returns in S_NEXT.
    task automatic run_subframe(input int n, input int rel_done, input bit coinc,
                                input int ch, input logic [15:0] base);
        logic [15:0] smp;
        logic [15:0] rel;
        #1;
        check_value("pf_addr", 32'(read_addr), 32'(base));
        check_value("pf_rst", 32'(dec_bus.dec_reset), 32'd1);
        check_value("pf_en", 32'(dec_bus.dec_enable), 32'd0);
        tick();
        check_value("ld_addr", 32'(read_addr), 32'(base));
        check_value("ld_rst", 32'(dec_bus.dec_reset), 32'd1);
        tick();
        for (int i = 0; i < n; i++) begin
            smp = 16'(i * 257 + ch * 31 - 500);
            rel = (coinc && i == n - 1) ? 16'(rel_done) : 16'(i);
            dec_bus.dec_read_addr    = rel;
            dec_bus.dec_sample_valid = 1'b1;
            dec_bus.dec_sample       = smp;
            dec_bus.dec_frame_done   = coinc && (i == n - 1);
            #1;
            check_value("run_addr", 32'(read_addr), 32'(16'(base + rel)));
            check_value("run_en", 32'(dec_bus.dec_enable), 32'd1);
            check_value("run_rst", 32'(dec_bus.dec_reset), 32'd0);
            tick();
            dec_bus.dec_sample_valid = 1'b0;
            dec_bus.dec_frame_done   = 1'b0;
            check_value("out_valid", 32'(sample_valid), 32'd1);
            check_value("out_sample", 32'(sample), 32'(smp));
            check_value("out_chan", 32'(channel), 32'(ch));
            check_value("out_idx", 32'(sample_idx), 32'(i));
        end
        if (!coinc) begin
            dec_bus.dec_read_addr  = 16'(rel_done);
            dec_bus.dec_frame_done = 1'b1;
            tick();
            dec_bus.dec_frame_done = 1'b0;
            check_value("next_valid", 32'(sample_valid), 32'd0);
        end
        check_value("next_en", 32'(dec_bus.dec_enable), 32'd0);
        check_value("next_busy", 32'(busy), 32'd1);
        $display("subframe ch=%0d samples=%0d base=0x%04h rel_done=%0d", ch, n, base, rel_done);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        block_size = '0;
        channels   = '0;
        base_addr  = '0;
        dec_bus.dec_read_addr    = '0;
        dec_bus.dec_sample_valid = 1'b0;
        dec_bus.dec_sample       = '0;
        dec_bus.dec_frame_done   = 1'b0;
        tick();
        tick();
        check_value("rst_addr", 32'(read_addr), 32'd0);
        check_value("rst_dec_rst", 32'(dec_bus.dec_reset), 32'd1);
        check_value("rst_dec_en", 32'(dec_bus.dec_enable), 32'd0);
        check_value("rst_blk", 32'(dec_bus.dec_block_size), 32'd0);
        check_value("rst_valid", 32'(sample_valid), 32'd0);
        check_value("rst_idx", 32'(sample_idx), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_fd", 32'(frame_done), 32'd0);
        check_value("rst_err", 32'(error), 32'd0);
        rst = 1'b0;
        tick();

        // Mono frame
        start_frame(16'd16, 4'd1, 16'h0010);
        run_subframe(16, 5, 1'b0, 0, 16'h0010);
        check_value("mono_err_next", 32'(error), 32'd0);
        tick();
        check_value("mono_fd", 32'(frame_done), 32'd1);
        check_value("mono_err", 32'(error), 32'd0);
        tick();
        check_value("mono_fd_end", 32'(frame_done), 32'd0);
        check_value("mono_idle", 32'(busy), 32'd0);
        $display("frame mono done");

        // Stereo frame: ch1 base = 0 + 7 + 1
        start_frame(16'd4, 4'd2, 16'h0000);
        run_subframe(4, 7, 1'b0, 0, 16'h0000);
        tick();
        check_value("st_no_fd_mid", 32'(frame_done), 32'd0);
        run_subframe(4, 3, 1'b0, 1, 16'h0008);
        check_value("st_err", 32'(error), 32'd0);
        tick();
        check_value("st_fd", 32'(frame_done), 32'd1);
        tick();
        check_value("st_fd_once", 32'(frame_done), 32'd0);
        $display("frame stereo done");

        // Short subframe: 15 of 16 samples
        start_frame(16'd16, 4'd1, 16'h0100);
        run_subframe(15, 15, 1'b0, 0, 16'h0100);
        check_value("short_err_next", 32'(error), 32'd1);
        tick();
        check_value("short_fd", 32'(frame_done), 32'd1);
        check_value("short_err_done", 32'(error), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_value("short_err_idle", 32'(error), 32'd1);
        end
        $display("frame short done");

        // Reset during sample 6 of ch0
        start_frame(16'd16, 4'd1, 16'h0020);
        tick();
        tick();
        for (int i = 0; i <= 6; i++) begin
            dec_bus.dec_read_addr    = 16'(i);
            dec_bus.dec_sample_valid = 1'b1;
            dec_bus.dec_sample       = 16'(i);
            if (i == 6) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        dec_bus.dec_sample_valid = 1'b0;
        check_value("abort_busy", 32'(busy), 32'd0);
        check_value("abort_dec_rst", 32'(dec_bus.dec_reset), 32'd1);
        check_value("abort_dec_en", 32'(dec_bus.dec_enable), 32'd0);
        check_value("abort_valid", 32'(sample_valid), 32'd0);
        check_value("abort_err", 32'(error), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_value("abort_no_fd", 32'(frame_done), 32'd0);
            tick();
        end
        $display("frame aborted by reset");

        // Coincident last strobe, channels=0 treated as mono
        start_frame(16'd16, 4'd0, 16'h0030);
        run_subframe(16, 20, 1'b1, 0, 16'h0030);
        check_value("coinc_err", 32'(error), 32'd0);
        tick();
        check_value("coinc_fd", 32'(frame_done), 32'd1);
        tick();
        check_value("coinc_idle", 32'(busy), 32'd0);
        $display("frame coincident done");

`ifdef SUBFRAME_SEQ_WATCHDOG_EN
        // Decoder never finishes: trip on run cycle 100
        start_frame(16'd16, 4'd1, 16'h0040);
        tick();
        tick();
        for (int c = 1; c < 100; c++) begin
            if (c == 99) check_value("wd_no_fd", 32'(frame_done), 32'd0);
            tick();
        end
        check_value("wd_dec_rst", 32'(dec_bus.dec_reset), 32'd1);
        tick();
        check_value("wd_fd", 32'(frame_done), 32'd1);
        check_value("wd_err", 32'(error), 32'd1);
        tick();
        check_value("wd_idle", 32'(busy), 32'd0);
        $display("frame watchdog done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
